// File: rtl/v810_icache_tagctl.sv
// Tag-side controller for the direct-mapped instruction cache.
// Drives the tag RAM read address and write port, serves fetch lookups,
// requests line fills on a miss, and runs range / post-reset invalidation.
// Every output is a register; the tag RAM read data is the only input
// that feeds a decision combinationally (the hit compare in LOOKUP).

module v810_icache_tagctl #(
    parameter int IDX_W = 7,
    parameter int OFS_W = 3,
    parameter int TAG_W = 22
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               en,
    output logic               busy,

    input  logic               lk_req,
    input  logic [31:0]        lk_addr,
    output logic               lk_ack,
    output logic               lk_hit,
    output logic               lk_err,

    output logic               fill_req,
    output logic [31:0]        fill_addr,
    input  logic               fill_ack,
    input  logic               fill_err,

    input  logic               clr_req,
    input  logic [IDX_W-1:0]   clr_start,
    input  logic [IDX_W:0]     clr_count,
    output logic               clr_done,

    output logic [IDX_W-1:0]   tr_rd_addr,
    input  logic [TAG_W:0]     tr_rd_data,
    output logic               tr_wr_en,
    output logic [IDX_W-1:0]   tr_wr_addr,
    output logic [TAG_W:0]     tr_wr_data
);

    // state  | meaning
    // RSTCLR | after reset: write {0,0} to every line, no clr_done
    // IDLE   | sample clr_req (priority) then lk_req
    // LOOKUP | tag RAM read of the latched index, hit compare
    // FILL   | fill_req held with a stable fill_addr until fill_ack
    // WRTAG  | write {1,tag} for the freshly filled line
    // CLEAR  | write {0,0} at start+k, index wrapping, then clr_done

    localparam int LINES = 2 ** IDX_W;

    typedef enum logic [2:0] {
        S_RSTCLR,
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WRTAG,
        S_CLEAR
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W:0]     left;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic               hit;
    logic               unused_ofs;

    // Resident when the stored entry is valid and its tag matches the request.
    assign hit = tr_rd_data[TAG_W] && (tr_rd_data[TAG_W-1:0] == req_tag);

    // Byte offset within the line never reaches the tag RAM.
    assign unused_ofs = ^lk_addr[OFS_W-1:0];

    // Controller FSM with registered outputs. The read address is parked one
    // index past any line being written so the RAM never sees a same-index
    // read-during-write.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= S_RSTCLR;
            ptr        <= '0;
            left       <= (IDX_W+1)'(LINES);
            req_tag    <= '0;
            req_idx    <= '0;
            busy       <= 1'b0;
            lk_ack     <= 1'b0;
            lk_hit     <= 1'b0;
            lk_err     <= 1'b0;
            fill_req   <= 1'b0;
            fill_addr  <= '0;
            clr_done   <= 1'b0;
            tr_rd_addr <= '0;
            tr_wr_en   <= 1'b0;
            tr_wr_addr <= '0;
            tr_wr_data <= '0;
        end else begin
            lk_ack   <= 1'b0;
            lk_hit   <= 1'b0;
            lk_err   <= 1'b0;
            clr_done <= 1'b0;
            tr_wr_en <= 1'b0;

            case (state)
                S_RSTCLR, S_CLEAR: begin
                    if (left != '0) begin
                        busy       <= 1'b1;
                        tr_wr_en   <= 1'b1;
                        tr_wr_addr <= ptr;
                        tr_wr_data <= '0;
                        tr_rd_addr <= ptr + 1'b1;
                        ptr        <= ptr + 1'b1;
                        left       <= left - 1'b1;
                    end else begin
                        busy     <= 1'b0;
                        clr_done <= (state == S_CLEAR);
                        state    <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (clr_req) begin
                        if (clr_count == '0) begin
                            clr_done <= 1'b1;
                        end else begin
                            ptr   <= clr_start;
                            left  <= clr_count;
                            busy  <= 1'b1;
                            state <= S_CLEAR;
                        end
                    end else if (lk_req) begin
                        req_tag <= lk_addr[31 -: TAG_W];
                        req_idx <= lk_addr[OFS_W +: IDX_W];
                        if (en) begin
                            tr_rd_addr <= lk_addr[OFS_W +: IDX_W];
                            busy       <= 1'b1;
                            state      <= S_LOOKUP;
                        end else begin
                            lk_ack <= 1'b1;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (hit) begin
                        lk_ack <= 1'b1;
                        lk_hit <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        fill_req  <= 1'b1;
                        fill_addr <= {req_tag, req_idx, {OFS_W{1'b0}}};
                        state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (fill_ack) begin
                        fill_req <= 1'b0;
                        if (fill_err) begin
                            lk_ack <= 1'b1;
                            lk_err <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            tr_wr_en   <= 1'b1;
                            tr_wr_addr <= req_idx;
                            tr_wr_data <= {1'b1, req_tag};
                            tr_rd_addr <= req_idx + 1'b1;
                            state      <= S_WRTAG;
                        end
                    end
                end

                S_WRTAG: begin
                    lk_ack <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v810_icache_tagctl.sv
// Bench for v810_icache_tagctl: the bench owns the tag RAM, keeps an
// abstract image of what the RAM must hold, and turns each transaction
// into a per-cycle list of expected outputs that a single compare
// process checks on the falling edge.

module tb_v810_icache_tagctl;

    localparam int IDX_W = 7;
    localparam int OFS_W = 3;
    localparam int TAG_W = 22;
    localparam int LINES = 128;

    logic               clk;
    logic               res_n;
    logic               en;
    logic               busy;
    logic               lk_req;
    logic [31:0]        lk_addr;
    logic               lk_ack;
    logic               lk_hit;
    logic               lk_err;
    logic               fill_req;
    logic [31:0]        fill_addr;
    logic               fill_ack;
    logic               fill_err;
    logic               clr_req;
    logic [IDX_W-1:0]   clr_start;
    logic [IDX_W:0]     clr_count;
    logic               clr_done;
    logic [IDX_W-1:0]   tr_rd_addr;
    logic [TAG_W:0]     tr_rd_data;
    logic               tr_wr_en;
    logic [IDX_W-1:0]   tr_wr_addr;
    logic [TAG_W:0]     tr_wr_data;

    v810_icache_tagctl #(.IDX_W(IDX_W), .OFS_W(OFS_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .en         (en),
        .busy       (busy),
        .lk_req     (lk_req),
        .lk_addr    (lk_addr),
        .lk_ack     (lk_ack),
        .lk_hit     (lk_hit),
        .lk_err     (lk_err),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_ack   (fill_ack),
        .fill_err   (fill_err),
        .clr_req    (clr_req),
        .clr_start  (clr_start),
        .clr_count  (clr_count),
        .clr_done   (clr_done),
        .tr_rd_addr (tr_rd_addr),
        .tr_rd_data (tr_rd_data),
        .tr_wr_en   (tr_wr_en),
        .tr_wr_addr (tr_wr_addr),
        .tr_wr_data (tr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM: asynchronous read, synchronous write, never reset.
    logic [TAG_W:0] ram [LINES];
    assign tr_rd_data = ram[tr_rd_addr];
    always @(posedge clk) if (tr_wr_en) ram[tr_wr_addr] <= tr_wr_data;

    // Expected tag RAM contents.
    logic [TAG_W:0] mram [LINES];

    typedef struct packed {
        logic               busy;
        logic               ack;
        logic               hit;
        logic               err;
        logic               fill;
        logic [31:0]        faddr;
        logic               done;
        logic               wr;
        logic [IDX_W-1:0]   waddr;
        logic [TAG_W:0]     wdata;
        logic               rd_chk;
        logic [IDX_W-1:0]   raddr;
    } exp_t;

    exp_t exq[$];
    exp_t ce;
    int nvec = 0;
    int nerr = 0;

    logic        last_hit, last_err;
    logic [31:0] last_faddr;
    int          fill_cycles = 0;
    int          ack_cnt = 0;
    logic [29:0] wr_log[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Single compare point: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exq.size() > 0) begin
            ce = exq.pop_front();
            chk("busy",     busy,     ce.busy);
            chk("lk_ack",   lk_ack,   ce.ack);
            chk("lk_hit",   lk_hit,   ce.hit);
            chk("lk_err",   lk_err,   ce.err);
            chk("fill_req", fill_req, ce.fill);
            chk("clr_done", clr_done, ce.done);
            chk("tr_wr_en", tr_wr_en, ce.wr);
            if (ce.fill)   chk("fill_addr",  fill_addr,  ce.faddr);
            if (ce.wr)     chk("tr_wr_addr", tr_wr_addr, ce.waddr);
            if (ce.wr)     chk("tr_wr_data", tr_wr_data, ce.wdata);
            if (ce.rd_chk) chk("tr_rd_addr", tr_rd_addr, ce.raddr);
            if (tr_wr_en)  chk("rd_wr_same_idx", tr_rd_addr != tr_wr_addr, 1);
        end
        if (lk_ack) begin
            last_hit = lk_hit;
            last_err = lk_err;
            ack_cnt++;
        end
        if (fill_req) begin
            last_faddr = fill_addr;
            fill_cycles++;
        end
        if (tr_wr_en) wr_log.push_back({tr_wr_addr, tr_wr_data});
    end

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return a[OFS_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        exq.push_back(e);
    endtask

    task automatic idle_n(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) tick(e);
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        tick(e);
        res_n = 1'b0;
        lk_req = 1'b0; clr_req = 1'b0; fill_ack = 1'b0; fill_err = 1'b0;
        #1;
        chk("rst_fill_req_now", fill_req, 0);
        chk("rst_busy_now", busy, 0);
        tick(e);
        tick(e);
        res_n = 1'b1;
        for (int k = 0; k < LINES; k++) begin
            e = '0; e.busy = 1'b1; e.wr = 1'b1; e.waddr = 7'(k); e.wdata = '0;
            tick(e);
            mram[k] = '0;
        end
        e = '0;
        tick(e);
    endtask

    // One lookup from IDLE; returns in the cycle where lk_ack is expected.
    task automatic do_lookup(input logic [31:0] a, input logic en_v, input int d,
                             input logic ferr, input int rst_at);
        exp_t e;
        logic [IDX_W-1:0] ix;
        logic [TAG_W-1:0] tg;
        ix = idx_of(a);
        tg = tag_of(a);
        lk_req = 1'b1; lk_addr = a; en = en_v;
        e = '0;
        if (!en_v) begin
            e.ack = 1'b1;
            tick(e);
            lk_req = 1'b0;
            return;
        end
        e.busy = 1'b1; e.rd_chk = 1'b1; e.raddr = ix;
        tick(e);
        lk_req = 1'b0;
        en = 1'($urandom_range(0, 1));
        if (mram[ix] == {1'b1, tg}) begin
            e = '0; e.ack = 1'b1; e.hit = 1'b1;
            tick(e);
            return;
        end
        for (int c = 1; c <= d; c++) begin
            if (rst_at == c) begin
                do_reset();
                return;
            end
            e = '0; e.busy = 1'b1; e.fill = 1'b1; e.faddr = {tg, ix, 3'b000};
            tick(e);
            if (c == d) begin
                fill_ack = 1'b1;
                fill_err = ferr;
            end
        end
        if (ferr) begin
            e = '0; e.ack = 1'b1; e.err = 1'b1;
            tick(e);
            fill_ack = 1'b0; fill_err = 1'b0;
            return;
        end
        e = '0; e.busy = 1'b1; e.wr = 1'b1; e.waddr = ix; e.wdata = {1'b1, tg};
        tick(e);
        fill_ack = 1'b0; fill_err = 1'b0;
        mram[ix] = {1'b1, tg};
        e = '0; e.ack = 1'b1;
        tick(e);
    endtask

    // One range invalidation from IDLE; returns in the clr_done cycle.
    task automatic do_clear(input logic [IDX_W-1:0] st, input logic [IDX_W:0] cnt);
        exp_t e;
        clr_req = 1'b1; clr_start = st; clr_count = cnt;
        e = '0;
        if (cnt == 0) begin
            e.done = 1'b1;
            tick(e);
            clr_req = 1'b0;
            return;
        end
        e.busy = 1'b1;
        tick(e);
        clr_req = 1'b0;
        for (int k = 0; k < int'(cnt); k++) begin
            e = '0; e.busy = 1'b1; e.wr = 1'b1;
            e.waddr = 7'((int'(st) + k) % LINES); e.wdata = '0;
            tick(e);
            mram[(int'(st) + k) % LINES] = '0;
        end
        e = '0; e.done = 1'b1;
        tick(e);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [TAG_W-1:0] tg;
        logic [IDX_W-1:0] ix;
        int r;
        tg = 22'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) tg = 22'h3FFFFF;
        r = $urandom_range(0, 9);
        ix = (r >= 8) ? 7'(118 + r) : 7'(r);
        return {tg, ix, 3'($urandom_range(0, 7))};
    endfunction

    initial begin
        #1_000_000;
        nerr++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        int f0, a0;
        logic [31:0] a;
        res_n = 1'b0; en = 1'b1; lk_req = 1'b0; lk_addr = '0;
        fill_ack = 1'b0; fill_err = 1'b0; clr_req = 1'b0;
        clr_start = '0; clr_count = '0;
        for (int i = 0; i < LINES; i++) ram[i] = 23'($urandom);

        do_reset();

        // 0x0000_1040: index 8, tag 4
        wr_log.delete();
        do_lookup(32'h0000_1040, 1'b1, 3, 1'b0, 0);
        idle_n(1);
        chk("t2_faddr", last_faddr, 32'h0000_1040);
        chk("t2_wr_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("t2_wr", wr_log[0], {7'd8, 23'h40_0004});
        chk("t2_miss", last_hit, 0);
        do_lookup(32'h0000_1040, 1'b1, 1, 1'b0, 0);
        idle_n(1);
        chk("t2_rehit", last_hit, 1);

        // 0x0000_2040: same index 8, tag 8, evicts the previous line
        wr_log.delete();
        do_lookup(32'h0000_2040, 1'b1, 2, 1'b0, 0);
        idle_n(1);
        if (wr_log.size() > 0) chk("t3_wr", wr_log[0], {7'd8, 23'h40_0008});
        do_lookup(32'h0000_1040, 1'b1, 1, 1'b0, 0);
        idle_n(1);
        chk("t3_old_miss", last_hit, 0);

        // Wrapping range clear, then an empty one
        wr_log.delete();
        do_clear(7'd126, 8'd4);
        idle_n(1);
        chk("t4_wr_cnt", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk("t4_wr0", wr_log[0], {7'd126, 23'd0});
            chk("t4_wr1", wr_log[1], {7'd127, 23'd0});
            chk("t4_wr2", wr_log[2], {7'd0, 23'd0});
            chk("t4_wr3", wr_log[3], {7'd1, 23'd0});
        end
        wr_log.delete();
        do_clear(7'd5, 8'd0);
        idle_n(1);
        chk("t4_zero_writes", wr_log.size(), 0);

        // Fill error: no tag write, retry misses again
        wr_log.delete();
        do_lookup(32'h0000_3058, 1'b1, 2, 1'b1, 0);
        idle_n(1);
        chk("t5_err", last_err, 1);
        chk("t5_no_write", wr_log.size(), 0);
        do_lookup(32'h0000_3058, 1'b1, 1, 1'b0, 0);
        idle_n(1);
        chk("t5_retry_miss", last_hit, 0);

        // Disabled cache
        f0 = fill_cycles; a0 = ack_cnt;
        do_lookup(32'h0000_3058, 1'b0, 1, 1'b0, 0);
        idle_n(1);
        chk("t6_no_fill", fill_cycles - f0, 0);
        chk("t6_one_ack", ack_cnt - a0, 1);
        chk("t6_nohit", last_hit, 0);

        // Clear and lookup requested together: clear first
        lk_req = 1'b1; lk_addr = 32'h0000_2040; en = 1'b1;
        do_clear(7'd8, 8'd1);
        do_lookup(32'h0000_2040, 1'b1, 1, 1'b0, 0);
        idle_n(1);
        chk("t6_cleared_miss", last_hit, 0);

        // Reset pulse in the middle of a fill
        do_lookup(32'h0000_5000, 1'b1, 4, 1'b0, 3);

        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 99);
            a = rand_addr();
            if (r < 60) begin
                do_lookup(a, 1'($urandom_range(0, 9) != 0), $urandom_range(1, 4),
                          1'($urandom_range(0, 7) == 0), 0);
            end else if (r < 75) begin
                do_clear(7'($urandom_range(0, 127)),
                         ($urandom_range(0, 9) == 0) ? 8'd128 : 8'($urandom_range(0, 8)));
            end else if (r < 85) begin
                lk_req = 1'b1; lk_addr = a; en = 1'b1;
                do_clear(idx_of(a), 8'($urandom_range(0, 3)));
                do_lookup(a, 1'b1, $urandom_range(1, 3), 1'b0, 0);
            end else if (r < 97) begin
                idle_n($urandom_range(1, 3));
            end else begin
                do_lookup(a, 1'b1, 4, 1'b0, $urandom_range(2, 4));
            end
        end

        idle_n(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
